// File: rtl/cmd_engine_pkg.sv
// Shared opcodes, reply characters, FSM state and transmit-source encodings for cmd_engine.
package cmd_engine_pkg;

    localparam logic [7:0] OP_SET_HASH = 8'h01;
    localparam logic [7:0] OP_PROC     = 8'h02;
    localparam logic [7:0] OP_RET      = 8'h03;
    localparam logic [7:0] OP_TEST     = 8'h04;
    localparam logic [7:0] OP_STR_LEN  = 8'h05;
    localparam logic [7:0] OP_VER      = 8'h06;

    localparam logic [7:0] CHAR_ACK  = 8'h01;
    localparam logic [7:0] CHAR_NACK = 8'h00;

    localparam int              TX_W       = 16;
    localparam logic [TX_W-1:0] TEST_BYTES = 16'd10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HASH   = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_WAIT   = 3'd4,
        S_STRLEN = 3'd5,
        S_TX     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_BYTE = 2'd0,
        SRC_RET  = 2'd1,
        SRC_TEST = 2'd2
    } tx_src_t;

endpackage

// File: rtl/cmd_tx_seq.sv
// Reply sequencer: sends i_count bytes, one per cycle with i_ready; o_remain selects the byte.
module cmd_tx_seq
    import cmd_engine_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [TX_W-1:0] i_count,
    input  logic            i_ready,
    output logic            o_busy,
    output logic            o_fire,
    output logic            o_last,
    output logic [TX_W-1:0] o_remain
);

    logic [TX_W-1:0] r_remain;

    always_ff @(posedge clk) begin
        if (reset)
            r_remain <= '0;
        else if (i_load)
            r_remain <= i_count;
        else if (o_fire)
            r_remain <= r_remain - 1'b1;
    end

    assign o_busy   = (r_remain != '0);
    assign o_fire   = o_busy && i_ready;
    assign o_last   = o_fire && (r_remain == TX_W'(1));
    assign o_remain = r_remain;

endmodule

// File: rtl/cmd_engine.sv
// Byte-stream command parser between the host link and the md5 process block.
// Define CMD_TIMEOUT_EN to abort receive phases with a NACK after TIMEOUT_CYC idle cycles.
//
// state    | meaning
// S_IDLE   | waiting for an opcode byte
// S_HASH   | shifting in target-hash bytes
// S_LEN    | shifting in the PROC byte count
// S_DATA   | forwarding PROC data bytes to the process block
// S_WAIT   | waiting for proc_done
// S_STRLEN | shifting in the 2-byte string length
// S_TX     | cmd_tx_seq is sending a reply
module cmd_engine
    import cmd_engine_pkg::*;
#(
    parameter int          NUM_LEDS    = 8,
    parameter int          HASH_BYTES  = 16,
    parameter int          LEN_BYTES   = 2,
    parameter int          POS_BYTES   = 2,
    parameter logic [15:0] STR_LEN_RST = 16'h98,
    parameter logic [7:0]  VERSION     = 8'h02,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rxd_data,
    input  logic                    rxd_data_ready,
    input  logic                    txd_ready_next,
    output logic                    txd_start,
    output logic [7:0]              txd_data,
    input  logic                    proc_done,
    input  logic                    proc_match,
    input  logic [POS_BYTES*8-1:0]  proc_byte_pos,
    input  logic [7:0]              proc_match_char,
    output logic                    proc_start,
    output logic [LEN_BYTES*8-1:0]  proc_num_bytes,
    output logic [7:0]              proc_data,
    output logic                    proc_data_valid,
    output logic                    proc_match_char_next,
    output logic [HASH_BYTES*8-1:0] proc_target_hash,
    output logic [15:0]             proc_str_len,
    output logic [NUM_LEDS-1:0]     led
);

    localparam int HW = HASH_BYTES * 8;
    localparam int NW = LEN_BYTES * 8;
    localparam int PW = POS_BYTES * 8;

    state_t          r_state, w_next;
    tx_src_t         r_src, w_src;
    logic [7:0]      r_reply, w_reply;
    logic [HW-1:0]   r_hash;
    logic [NW-1:0]   r_num_bytes, r_cnt, w_len_full;
    logic [15:0]     r_str_len;
    logic            r_proc_start, r_proc_valid;
    logic [7:0]      r_proc_data;
    logic            w_tx_load, w_tx_busy, w_tx_fire, w_tx_last, w_timeout;
    logic [TX_W-1:0] w_tx_count, w_tx_remain, w_chars, w_pos_idx;
    logic [PW-1:0]   w_pos_shift;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_timer;
    logic          w_rx_phase;

    assign w_rx_phase = (r_state == S_HASH) || (r_state == S_LEN) ||
                        (r_state == S_DATA) || (r_state == S_STRLEN);

    always_ff @(posedge clk) begin
        if (reset)
            r_timer <= '0;
        else if (rxd_data_ready)
            r_timer <= TW'(TIMEOUT_CYC);
        else if (r_timer != '0)
            r_timer <= r_timer - 1'b1;
    end

    assign w_timeout = w_rx_phase && !rxd_data_ready && (r_timer == TW'(1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_chars = {3'b000, r_str_len[15:3]};

    always_comb begin
        w_next     = r_state;
        w_src      = r_src;
        w_reply    = r_reply;
        w_tx_load  = 1'b0;
        w_tx_count = '0;
        w_len_full = (r_num_bytes << 8) | NW'(rxd_data);
        case (r_state)
            S_IDLE: if (rxd_data_ready) begin
                case (rxd_data)
                    OP_SET_HASH: w_next = S_HASH;
                    OP_PROC:     w_next = S_LEN;
                    OP_STR_LEN:  w_next = S_STRLEN;
                    OP_RET:  begin w_src = SRC_RET;  w_tx_count = TX_W'(POS_BYTES) + w_chars; w_tx_load = 1'b1; end
                    OP_TEST: begin w_src = SRC_TEST; w_tx_count = TEST_BYTES; w_tx_load = 1'b1; end
                    OP_VER:  begin w_src = SRC_BYTE; w_reply = VERSION;   w_tx_count = TX_W'(1); w_tx_load = 1'b1; end
                    default: begin w_src = SRC_BYTE; w_reply = CHAR_NACK; w_tx_count = TX_W'(1); w_tx_load = 1'b1; end
                endcase
            end
            S_HASH, S_STRLEN, S_LEN, S_DATA: begin
                if (w_timeout) begin
                    w_src = SRC_BYTE; w_reply = CHAR_NACK; w_tx_count = TX_W'(1); w_tx_load = 1'b1;
                end else if (rxd_data_ready && r_cnt == NW'(1)) begin
                    if (r_state == S_LEN)
                        w_next = (w_len_full == '0) ? S_WAIT : S_DATA;
                    else if (r_state == S_DATA)
                        w_next = S_WAIT;
                    else begin
                        w_src = SRC_BYTE; w_reply = CHAR_ACK; w_tx_count = TX_W'(1); w_tx_load = 1'b1;
                    end
                end
            end
            S_WAIT: if (proc_done) begin
                w_src      = SRC_BYTE;
                w_reply    = proc_match ? CHAR_ACK : CHAR_NACK;
                w_tx_count = TX_W'(1);
                w_tx_load  = 1'b1;
            end
            S_TX: if (w_tx_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_tx_load)
            w_next = S_TX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src        <= SRC_BYTE;
            r_reply      <= 8'h00;
            r_hash       <= '0;
            r_num_bytes  <= '0;
            r_cnt        <= '0;
            r_str_len    <= STR_LEN_RST;
            r_proc_start <= 1'b0;
            r_proc_valid <= 1'b0;
            r_proc_data  <= 8'h00;
        end else begin
            r_state      <= w_next;
            r_src        <= w_src;
            r_reply      <= w_reply;
            r_proc_start <= 1'b0;
            r_proc_valid <= 1'b0;
            if (rxd_data_ready) begin
                case (r_state)
                    S_IDLE: begin
                        if (rxd_data == OP_SET_HASH) r_cnt <= NW'(HASH_BYTES);
                        if (rxd_data == OP_PROC)     r_cnt <= NW'(LEN_BYTES);
                        if (rxd_data == OP_STR_LEN)  r_cnt <= NW'(2);
                    end
                    S_HASH: begin
                        r_hash <= (r_hash << 8) | HW'(rxd_data);
                        r_cnt  <= r_cnt - 1'b1;
                    end
                    S_STRLEN: begin
                        r_str_len <= {r_str_len[7:0], rxd_data};
                        r_cnt     <= r_cnt - 1'b1;
                    end
                    S_LEN: begin
                        r_num_bytes <= w_len_full;
                        r_cnt       <= r_cnt - 1'b1;
                        // Last count byte: the data phase reuses r_cnt as its down-counter.
                        if (r_cnt == NW'(1)) begin
                            r_proc_start <= 1'b1;
                            r_cnt        <= w_len_full;
                        end
                    end
                    S_DATA: begin
                        r_proc_data  <= rxd_data;
                        r_proc_valid <= 1'b1;
                        r_cnt        <= r_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    cmd_tx_seq u_tx_seq (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_tx_load),
        .i_count  (w_tx_count),
        .i_ready  (txd_ready_next),
        .o_busy   (w_tx_busy),
        .o_fire   (w_tx_fire),
        .o_last   (w_tx_last),
        .o_remain (w_tx_remain)
    );

    // RET sends position bytes while more than w_chars remain, MSB first.
    assign w_pos_idx   = w_tx_remain - w_chars - 1'b1;
    assign w_pos_shift = proc_byte_pos >> {w_pos_idx, 3'b000};

    always_comb begin
        txd_data             = 8'h00;
        proc_match_char_next = 1'b0;
        if (w_tx_busy) begin
            case (r_src)
                SRC_BYTE: txd_data = r_reply;
                SRC_TEST: txd_data = w_tx_remain[7:0];
                SRC_RET: begin
                    if (w_tx_remain > w_chars)
                        txd_data = w_pos_shift[7:0];
                    else begin
                        txd_data             = proc_match_char;
                        proc_match_char_next = w_tx_fire;
                    end
                end
                default: txd_data = 8'h00;
            endcase
        end
    end

    assign txd_start        = w_tx_fire;
    assign proc_start       = r_proc_start;
    assign proc_num_bytes   = r_num_bytes;
    assign proc_data        = r_proc_data;
    assign proc_data_valid  = r_proc_valid;
    assign proc_target_hash = r_hash;
    assign proc_str_len     = r_str_len;
    assign led              = NUM_LEDS'(r_state);

endmodule

// File: tb/tb_cmd_engine.sv
// Scoreboard bench for cmd_engine: stimulus queues expected tx/proc bytes, a monitor pops and compares.
module tb_cmd_engine;

    localparam int TO_CYC = 50;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rxd_data = 8'h00;
    logic         rxd_data_ready = 1'b0;
    logic         txd_ready_next = 1'b1;
    logic         txd_start;
    logic [7:0]   txd_data;
    logic         proc_done = 1'b0;
    logic         proc_match = 1'b0;
    logic [15:0]  proc_byte_pos = 16'h0000;
    logic [7:0]   proc_match_char = 8'h41;
    logic         proc_start;
    logic [15:0]  proc_num_bytes;
    logic [7:0]   proc_data;
    logic         proc_data_valid;
    logic         proc_match_char_next;
    logic [127:0] proc_target_hash;
    logic [15:0]  proc_str_len;
    logic [7:0]   led;

    always #5 clk = ~clk;

    cmd_engine #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .rxd_data             (rxd_data),
        .rxd_data_ready       (rxd_data_ready),
        .txd_ready_next       (txd_ready_next),
        .txd_start            (txd_start),
        .txd_data             (txd_data),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .proc_start           (proc_start),
        .proc_num_bytes       (proc_num_bytes),
        .proc_data            (proc_data),
        .proc_data_valid      (proc_data_valid),
        .proc_match_char_next (proc_match_char_next),
        .proc_target_hash     (proc_target_hash),
        .proc_str_len         (proc_str_len),
        .led                  (led)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_pd[$];
    int         n_start = 0;
    int         n_mcn = 0;
    int         n_tx = 0;
    logic       toggle_rdy = 1'b0;
    logic [7:0] char_base = 8'h41;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (txd_start) begin
                n_tx++;
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%02h required=none", txd_data);
                end else
                    check("tx_byte", txd_data, exp_tx.pop_front());
                check("tx_ready", txd_ready_next, 1);
            end
            if (proc_data_valid) begin
                if (exp_pd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pd_unexpected actual=%02h required=none", proc_data);
                end else
                    check("proc_data", proc_data, exp_pd.pop_front());
            end
            if (proc_match_char_next) begin
                n_mcn++;
                check("mcn_with_start", txd_start, 1);
            end
            if (proc_start) n_start++;
        end
    end

    // Process-block model: the matched char advances after each next pulse.
    initial forever begin
        @(posedge clk);
        #1 proc_match_char = char_base + 8'(n_mcn);
    end

    initial forever begin
        @(posedge clk);
        #2 txd_ready_next = toggle_rdy ? ~txd_ready_next : 1'b1;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rxd_data       = b;
        rxd_data_ready = 1'b1;
        @(negedge clk);
        rxd_data_ready = 1'b0;
    endtask

    task automatic pulse_done(input logic m);
        @(negedge clk);
        proc_done  = 1'b1;
        proc_match = m;
        @(negedge clk);
        proc_done  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_pd.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_tx.size() != 0 || exp_pd.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_drain actual_pending=%0d required=0", name, exp_tx.size() + exp_pd.size());
            exp_tx.delete();
            exp_pd.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0;
        int t0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_txd_start", txd_start, 0);
        check("rst_txd_data", txd_data, 0);
        check("rst_proc_start", proc_start, 0);
        check("rst_proc_valid", proc_data_valid, 0);
        check("rst_proc_data", proc_data, 0);
        check("rst_num_bytes", proc_num_bytes, 0);
        check("rst_hash", proc_target_hash, 0);
        check("rst_str_len", proc_str_len, 16'h0098);
        check("rst_led", led, 0);

        exp_tx.push_back(8'h01);
        send(8'h01);
        for (int i = 0; i < 16; i++) send(8'(i));
        drain("set_hash");
        check("set_hash_value", proc_target_hash, 128'h000102030405060708090A0B0C0D0E0F);
        check("set_hash_idle", led, 0);

        exp_tx.push_back(8'h01);
        send(8'h05); send(8'h00); send(8'h28);
        drain("str_len");
        check("str_len_value", proc_str_len, 16'h0028);

        proc_byte_pos = 16'h1234;
        s0 = n_mcn;
        char_base = 8'h41 - 8'(n_mcn);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        for (int i = 0; i < 5; i++) exp_tx.push_back(8'h41 + 8'(i));
        send(8'h03);
        drain("ret");
        check("ret_mcn_pulses", n_mcn - s0, 5);
        check("ret_idle", led, 0);

        s0 = n_start;
        exp_pd.push_back(8'hAA); exp_pd.push_back(8'hBB); exp_pd.push_back(8'hCC);
        send(8'h02); send(8'h00); send(8'h03);
        send(8'hAA);
        pulse_done(1'b1);
        send(8'hBB); send(8'hCC);
        repeat (2) @(negedge clk);
        check("proc_start_count", n_start - s0, 1);
        check("proc_num_bytes", proc_num_bytes, 3);
        send(8'h06);
        exp_tx.push_back(8'h00);
        pulse_done(1'b0);
        drain("proc_nomatch");

        s0 = n_start;
        exp_pd.push_back(8'hAA); exp_pd.push_back(8'hBB); exp_pd.push_back(8'hCC);
        send(8'h02); send(8'h00); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        repeat (2) @(negedge clk);
        exp_tx.push_back(8'h01);
        pulse_done(1'b1);
        drain("proc_match");
        check("proc2_start_count", n_start - s0, 1);

        s0 = n_start;
        send(8'h02); send(8'h00); send(8'h00);
        repeat (2) @(negedge clk);
        check("proc0_start_count", n_start - s0, 1);
        check("proc0_num_bytes", proc_num_bytes, 0);
        exp_tx.push_back(8'h01);
        pulse_done(1'b1);
        drain("proc_zero");

        exp_tx.push_back(8'h00);
        send(8'h7F);
        drain("bad_opcode");
        exp_tx.push_back(8'h02);
        send(8'h06);
        drain("version");

        t0 = n_tx;
        toggle_rdy = 1'b1;
        for (int i = 10; i >= 1; i--) exp_tx.push_back(8'(i));
        send(8'h04);
        drain("test");
        toggle_rdy = 1'b0;
        check("test_tx_count", n_tx - t0, 10);

        send(8'h01);
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_hash", proc_target_hash, 0);
        check("rst_mid_led", led, 0);
        check("rst_mid_str_len", proc_str_len, 16'h0098);

`ifdef CMD_TIMEOUT_EN
        exp_tx.push_back(8'h00);
        send(8'h02); send(8'h00);
        drain("timeout");
        exp_tx.push_back(8'h02);
        send(8'h06);
        drain("after_timeout");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
